// File: rtl/map_row_fetcher.sv
// Double-buffered map row prefetcher: fills a back bank with one 30-tile map row per
// tile row and serves the front bank by pixel column. Define MAP_FETCH_OVERRUN_CNT_EN to add overrun_count.
module map_row_fetcher #(
  parameter int MAP_W      = 30,
  parameter int MAP_H      = 30,
  parameter int TILE_SHIFT = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [9:0]        line_y,
  output logic [ADDR_W-1:0] map_address,
  output logic              map_read,
  input  logic [DATA_W-1:0] map_readdata,
  input  logic [9:0]        pix_x,
  output logic [DATA_W-1:0] tile_code,
  output logic              tile_valid,
  output logic              busy
`ifdef MAP_FETCH_OVERRUN_CNT_EN
  ,
  output logic [7:0]        overrun_count
`endif
);

  localparam int IDX_W = $clog2(MAP_W);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(MAP_W - 1);
  localparam logic [9:0]        COLS       = 10'(MAP_W);
  localparam logic [9:0]        ROWS       = 10'(MAP_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(MAP_W);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                read_q, read_d;
  logic                busy_q, busy_d;
  logic                front_sel_q, front_sel_d;
  logic                front_valid_q, front_valid_d;
  logic                back_full_q, back_full_d;
  logic [DATA_W-1:0]   tile_code_q, tile_code_d;
  logic                tile_valid_q, tile_valid_d;
`ifdef MAP_FETCH_OVERRUN_CNT_EN
  logic [7:0]          ovr_q, ovr_d;
`endif

  logic [DATA_W-1:0]   bank_q [2][MAP_W];
  logic                we;
  logic                wr_bank;
  logic [IDX_W-1:0]    wr_idx;
  logic [9:0]          row;
  logic [9:0]          col;
  logic                fetch_ok;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    addr_d        = addr_q;
    read_d        = read_q;
    busy_d        = busy_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    back_full_d   = back_full_q;
    we            = 1'b0;
    wr_idx        = k_q - IDX_W'(1);
    wr_bank       = ~front_sel_q;
    row           = line_y >> TILE_SHIFT;
    fetch_ok      = (line_y[TILE_SHIFT-1:0] == '0) && (row < ROWS);
`ifdef MAP_FETCH_OVERRUN_CNT_EN
    ovr_d = ovr_q;
    if (line_start && busy_q && (ovr_q != '1))
      ovr_d = ovr_q + 8'd1;
`endif

    // A line_start always wins over the fetch in flight; back_full is 0 while busy,
    // so an aborted row can never be swapped in.
    if (line_start) begin
      if (back_full_q) begin
        front_sel_d   = ~front_sel_q;
        front_valid_d = 1'b1;
        back_full_d   = 1'b0;
      end
      if (fetch_ok) begin
        state_d = ISSUE;
        k_d     = '0;
        addr_d  = ADDR_W'(row) * ROW_STRIDE;
        read_d  = 1'b1;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ISSUE: begin
          we = (k_q != '0);
          if (k_q == LAST_IDX) begin
            state_d = DRAIN;
            read_d  = 1'b0;
          end else begin
            k_d    = k_q + IDX_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          we          = 1'b1;
          wr_idx      = LAST_IDX;
          back_full_d = 1'b1;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
        default: ;
      endcase
    end

    col = pix_x >> TILE_SHIFT;
    if (front_valid_q && (col < COLS)) begin
      tile_code_d  = bank_q[front_sel_q][col[IDX_W-1:0]];
      tile_valid_d = 1'b1;
    end else begin
      tile_code_d  = '0;
      tile_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      addr_q        <= '0;
      read_q        <= 1'b0;
      busy_q        <= 1'b0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      back_full_q   <= 1'b0;
      tile_code_q   <= '0;
      tile_valid_q  <= 1'b0;
`ifdef MAP_FETCH_OVERRUN_CNT_EN
      ovr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      addr_q        <= addr_d;
      read_q        <= read_d;
      busy_q        <= busy_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      back_full_q   <= back_full_d;
      tile_code_q   <= tile_code_d;
      tile_valid_q  <= tile_valid_d;
`ifdef MAP_FETCH_OVERRUN_CNT_EN
      ovr_q         <= ovr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      bank_q[wr_bank][wr_idx] <= map_readdata;
  end

  assign map_address = addr_q;
  assign map_read    = read_q;
  assign busy        = busy_q;
  assign tile_code   = tile_code_q;
  assign tile_valid  = tile_valid_q;
`ifdef MAP_FETCH_OVERRUN_CNT_EN
  assign overrun_count = ovr_q;
`endif

endmodule

// File: doc/map_row_fetcher.md
# map_row_fetcher

Read-side client of the 30x30 tile map RAM. It prefetches one map row (30 tile codes) per 16-line tile row into a double-buffered line store. It then serves tile codes to the VGA tile renderer by pixel column. It sits between the map RAM read port and the sprite/tile compositor, and only reads; CPU writes reach the RAM through its Avalon slave.

## Interface
Parameters:
- `MAP_W`, 30: tiles per map row.
- `MAP_H`, 30: map rows.
- `TILE_SHIFT`, 4: log2 of tile size in pixels (16x16 tiles).
- `ADDR_W`, 10: map RAM address width.
- `DATA_W`, 8: tile code width.

Ports:
- `clk` in 1: single clock, same domain as the map RAM.
- `reset` in 1: asynchronous, active-high.
- `line_start` in 1: one-cycle pulse per scanline.
- `line_y` in 10: line to prefetch for, i.e. displayed line + 1. Valid with `line_start`.
- `map_address` out ADDR_W: map RAM address.
- `map_read` out 1: read strobe; high while `map_address` is valid.
- `map_readdata` in DATA_W: RAM data, valid the cycle after its address.
- `pix_x` in 10: current pixel column.
- `tile_code` out DATA_W: tile code for `pix_x`, registered.
- `tile_valid` out 1: `tile_code` is meaningful.
- `busy` out 1: row fetch in progress.

## Operation
- Two banks of MAP_W x DATA_W each: front (displayed) and back (being filled). Flags: `front_valid`, `back_full`.
- The FSM states are IDLE, ISSUE and DRAIN.
- On `line_start`, the following happen in order on the same edge:
  - **Swap:** if `back_full`, swap front/back, set `front_valid`=1 and clear `back_full`.
  - **Fetch decision:** if `line_y[TILE_SHIFT-1:0]==0` and `(line_y>>TILE_SHIFT) < MAP_H`, start a fetch of row `r = line_y>>TILE_SHIFT` with base `r*MAP_W` and go to ISSUE. Otherwise no fetch.
- **ISSUE:** present `base+k` for k=0..MAP_W-1, one per cycle, with `map_read`=1. Data for index k is written to back[k] on the edge ending the cycle after address k. After k=MAP_W-1 the FSM goes to DRAIN.
- **DRAIN:** for one cycle, capture back[MAP_W-1], set `back_full`=1 and go to IDLE.
- **Overrun:** a `line_start` while `busy` aborts the current fetch. `back_full` stays 0, so no swap occurs for the aborted row. The new `line_start` is then evaluated by the fetch rule above; the fetch restarts from k=0 if it qualifies, else the FSM goes to IDLE.
- **Pixel side:** `col = pix_x>>TILE_SHIFT`.
  - If `col < MAP_W` and `front_valid`: `tile_code` <= front[col] and `tile_valid` <= 1.
  - Otherwise: `tile_code` <= 0 and `tile_valid` <= 0.
- Address arithmetic is unsigned, ADDR_W bits, and the maximum is 899. Rows >= MAP_H are never issued, so no address exceeds MAP_W*MAP_H-1.

## Timing
- Let `line_start` be sampled at edge E0. Then:
  - `map_read`=1 and `map_address`=base+k in cycle k after E0, for k=0..29.
  - `busy`=1 from E0 until E31.
  - `back_full` is set at E31.
  - `map_read` is 0 in cycles 30 and 31 (DRAIN).
- The swap takes effect at the next `line_start` after `back_full` is set.
- Pixel path latency is 1 cycle from `pix_x` to `tile_code`/`tile_valid`.
- Reset values: `map_address`=0, `map_read`=0, `busy`=0, `tile_code`=0, `tile_valid`=0, `front_valid`=0, `back_full`=0, FSM=IDLE. Bank contents are not reset.
- Reset asserted mid-fetch forces all outputs to their reset values immediately. The row is discarded.

## Configuration
- `MAP_FETCH_OVERRUN_CNT_EN`:
  - Defined: adds output `overrun_count` out 8. It increments, saturating at 255, on each `line_start` sampled while `busy`. It resets to 0.
  - Undefined: no port and no counter. Overrun behaviour is otherwise identical.

## Test plan
- Reset, then idle for 100 cycles -> `map_read`=0, `busy`=0, `tile_valid`=0 and `tile_code`=0 with any `pix_x`.
- RAM preloaded with mem[a]=a[7:0]. Pulse `line_start` with `line_y`=32 -> addresses 60..89 on consecutive cycles, `busy` high 31 cycles. Then pulse `line_start` with `line_y`=33, expecting:
  - no new fetch;
  - `pix_x`=0 -> `tile_code`=60, `tile_valid`=1;
  - `pix_x`=479 -> 89;
  - `pix_x`=480 -> `tile_code`=0, `tile_valid`=0.
- `line_start` with `line_y`=5, then 480 -> no `map_read`, `busy` stays 0, front bank unchanged.
- Overrun: start `line_y`=16, then at cycle 10 `line_start` with `line_y`=48 -> addresses restart at 90..119. The following `line_start` swaps in row 3 (`pix_x`=0 -> 90). `overrun_count`=1 when the macro is defined.
- Assert `reset` during cycle 15 of a fetch -> `map_read`/`busy` drop without waiting for a clock. After release, `tile_valid`=0 until a full fetch and swap complete.
